// File: rtl/pwm_demod.sv
// pwm_demod: recovers one 8-bit level per 256-cycle PWM frame.
// The block aligns to the frame via the rising edge, counts high cycles per
// frame, and emits the count as offset-binary and signed samples once locked.
module pwm_demod #(
   parameter int FRAME_LEN   = 256,
   parameter int LOCK_FRAMES = 4
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic              enable_in,
   input  logic              pwm_in,
   output logic [7:0]        level_out,
   output logic signed [7:0] sample_out,
   output logic              valid_out,
   output logic              locked_out,
   output logic              err_out
);

   localparam logic [7:0]    LAST_PHASE = 8'(FRAME_LEN - 1);
   localparam int            SIL_N      = LOCK_FRAMES * FRAME_LEN;
   localparam int            SW         = $clog2(SIL_N + 1);
   localparam int            GW         = $clog2(LOCK_FRAMES + 1);
   localparam logic [SW-1:0] SIL_LAST   = SW'(SIL_N - 1);
   localparam logic [GW-1:0] GOOD_LAST  = GW'(LOCK_FRAMES - 1);
   localparam logic [8:0]    STUCK_CNT  = 9'(FRAME_LEN);

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   // A frame that was high every cycle reads as full scale; anything above
   // the 8-bit range clips to 255.
   function automatic logic [7:0] sat_level(input logic [8:0] total);
      if (total == STUCK_CNT || total > 9'd255) return 8'd255;
      return total[7:0];
   endfunction

   state_t        state_q, state_d;
   logic          sync1_q, sync1_d;
   logic          s_q, s_d;
   logic          s_dly_q, s_dly_d;
   logic [7:0]    fcnt_q, fcnt_d;
   logic [8:0]    hcnt_q, hcnt_d;
   logic [GW-1:0] good_q, good_d;
   logic [SW-1:0] sil_q, sil_d;
   logic [7:0]    level_q, level_d;
   logic          valid_q, valid_d;
   logic          err_q, err_d;

   logic          rise;
   logic          close;
   logic          restart;
   logic [8:0]    total;

   // Next-state logic: synchronizer, frame counters and the HUNT/ACQUIRE/LOCKED FSM.
   always_comb begin
      sync1_d = pwm_in;
      s_d     = sync1_q;
      s_dly_d = s_q;

      rise    = s_q & ~s_dly_q;
      close   = (fcnt_q == LAST_PHASE);
      total   = hcnt_q + {8'd0, s_q};
      restart = 1'b0;

      state_d = state_q;
      fcnt_d  = close ? 8'd0 : fcnt_q + 8'd1;
      hcnt_d  = close ? 9'd0 : total;
      good_d  = good_q;
      sil_d   = '0;
      level_d = level_q;
      valid_d = 1'b0;
      err_d   = 1'b0;

      if (!enable_in) begin
         state_d = HUNT;
         fcnt_d  = 8'd0;
         hcnt_d  = 9'd0;
         good_d  = '0;
      end else begin
         case (state_q)
            HUNT: begin
               if (rise) begin
                  restart = 1'b1;
                  state_d = ACQUIRE;
                  good_d  = '0;
               end else if (!s_q) begin
                  // Long silence: lock onto the free-running phase.
                  if (sil_q == SIL_LAST) state_d = LOCKED;
                  else                   sil_d   = sil_q + SW'(1);
               end
            end
            ACQUIRE: begin
               if (rise && fcnt_q != 8'd0) begin
                  err_d   = 1'b1;
                  restart = 1'b1;
                  good_d  = '0;
               end else if (close) begin
                  if (total == STUCK_CNT) begin
                     err_d = 1'b1;
                  end else if (good_q == GOOD_LAST) begin
                     state_d = LOCKED;
                     level_d = sat_level(total);
                     valid_d = 1'b1;
                  end else begin
                     good_d = good_q + GW'(1);
                  end
               end
            end
            LOCKED: begin
               // An early rise beats a coincident close: the partial frame is dropped.
               if (rise && fcnt_q != 8'd0) begin
                  err_d   = 1'b1;
                  restart = 1'b1;
                  state_d = ACQUIRE;
                  good_d  = '0;
               end else if (close) begin
                  level_d = sat_level(total);
                  valid_d = 1'b1;
                  err_d   = (total == STUCK_CNT);
               end
            end
            default: state_d = HUNT;
         endcase

         // The rise cycle itself is sample 0 of the new frame.
         if (restart) begin
            fcnt_d = 8'd1;
            hcnt_d = {8'd0, s_q};
         end
      end
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= HUNT;
         sync1_q <= 1'b0;
         s_q     <= 1'b0;
         s_dly_q <= 1'b0;
         fcnt_q  <= 8'd0;
         hcnt_q  <= 9'd0;
         good_q  <= '0;
         sil_q   <= '0;
         level_q <= 8'd128;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sync1_q <= sync1_d;
         s_q     <= s_d;
         s_dly_q <= s_dly_d;
         fcnt_q  <= fcnt_d;
         hcnt_q  <= hcnt_d;
         good_q  <= good_d;
         sil_q   <= sil_d;
         level_q <= level_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign level_out  = level_q;
   assign sample_out = signed'({~level_q[7], level_q[6:0]});
   assign valid_out  = valid_q;
   assign locked_out = (state_q == LOCKED);
   assign err_out    = err_q;

endmodule

// File: tb/tb_pwm_demod.sv
// tb_pwm_demod: directed PWM streams with hand-computed frame timing and levels.
module tb_pwm_demod;

   logic              clk_in = 1'b0;
   logic              rst_n_in;
   logic              enable_in;
   logic              pwm_in;
   logic [7:0]        level_out;
   logic signed [7:0] sample_out;
   logic              valid_out;
   logic              locked_out;
   logic              err_out;

   pwm_demod #(.FRAME_LEN(256), .LOCK_FRAMES(4)) dut (
      .clk_in     (clk_in),
      .rst_n_in   (rst_n_in),
      .enable_in  (enable_in),
      .pwm_in     (pwm_in),
      .level_out  (level_out),
      .sample_out (sample_out),
      .valid_out  (valid_out),
      .locked_out (locked_out),
      .err_out    (err_out)
   );

   always #5 clk_in = ~clk_in;

   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   // Event log, sampled on the falling edge.
   int   v_cyc[$];
   int   v_lvl[$];
   int   v_smp[$];
   int   e_cyc[$];
   int   lr_cyc[$];
   int   lf_cyc[$];
   logic prev_locked = 1'b0;

   always @(negedge clk_in) begin
      if (rst_n_in) begin
         if (valid_out) begin
            v_cyc.push_back(cyc);
            v_lvl.push_back(int'(level_out));
            v_smp.push_back(int'(sample_out));
         end
         if (err_out) e_cyc.push_back(cyc);
         if (locked_out && !prev_locked) lr_cyc.push_back(cyc);
         if (!locked_out && prev_locked) lf_cyc.push_back(cyc);
      end
      prev_locked = locked_out;
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
   endtask

   function automatic int q_cnt(input int q[$], input int a, input int b);
      int n = 0;
      foreach (q[i]) if (q[i] >= a && q[i] <= b) n++;
      return n;
   endfunction

   function automatic int lvl_at(input int c);
      foreach (v_cyc[i]) if (v_cyc[i] == c) return v_lvl[i];
      return -999;
   endfunction

   function automatic int smp_at(input int c);
      foreach (v_cyc[i]) if (v_cyc[i] == c) return v_smp[i];
      return -999;
   endfunction

   // One PWM frame per 256 cycles, high while the frame phase is below lvl.
   task automatic gen(input int lvl, input int nframes);
      for (int f = 0; f < nframes; f++)
         for (int i = 0; i < 256; i++) begin
            pwm_in = (i < lvl);
            @(posedge clk_in); #1;
         end
   endtask

   task automatic hold(input logic val, input int n);
      for (int i = 0; i < n; i++) begin
         pwm_in = val;
         @(posedge clk_in); #1;
      end
   endtask

   int e0, p_b, p_c, p_d, p_e, s_slip, p_f, en0, x0;

   initial begin
      rst_n_in  = 1'b0;
      enable_in = 1'b1;
      pwm_in    = 1'b0;
      repeat (3) @(posedge clk_in);
      #1;
      check("rst level", int'(level_out), 128);
      check("rst sample", int'(sample_out), 0);
      check("rst valid", int'(valid_out), 0);
      check("rst locked", int'(locked_out), 0);
      check("rst err", int'(err_out), 0);
      rst_n_in = 1'b1;

      // Continuous stream: each phase starts on a frame boundary.
      e0 = cyc;      gen(100, 7);
      p_b = cyc;     gen(200, 3);
      p_c = cyc;     gen(255, 2);
      p_d = cyc;     gen(1, 2);
      p_e = cyc;     gen(64, 2);
      s_slip = cyc;  hold(1'b0, 37); gen(64, 6);
      p_f = cyc;     hold(1'b1, 768); hold(1'b0, 10);

      // Enable drop while the last stuck frame's 255 is still held.
      enable_in = 1'b0;
      en0 = cyc;
      hold(1'b0, 5);
      check("en level hold", int'(level_out), 255);
      check("en locked low", int'(locked_out), 0);
      hold(1'b0, 15);
      enable_in = 1'b1;
      x0 = cyc;
      hold(1'b0, 1600);

      // Level 100: sample 0 is 2 cycles after the drive edge, valid 1024 after that.
      check("A early valids", q_cnt(v_cyc, e0, e0 + 1025), 0);
      check("A first level", lvl_at(e0 + 1026), 100);
      check("A first sample", smp_at(e0 + 1026), -28);
      check("A lock rise", q_cnt(lr_cyc, e0 + 1026, e0 + 1026), 1);
      for (int k = 1; k < 4; k++)
         check($sformatf("A period %0d", k), lvl_at(e0 + 1026 + 256 * k), 100);
      check("A valid count", q_cnt(v_cyc, e0, p_b + 2), 4);

      check("B level", lvl_at(p_b + 258), 200);
      check("B no extra", q_cnt(v_cyc, p_b + 3, p_b + 257), 0);
      check("C level", lvl_at(p_c + 258), 255);
      check("C sample", smp_at(p_c + 258), 127);
      check("D level", lvl_at(p_d + 258), 1);
      check("D sample", smp_at(p_d + 258), -127);
      check("A-D errors", q_cnt(e_cyc, e0, p_e), 0);

      // Phase slip: rise lands at phase 37, error one cycle after the rise acts.
      check("E pre-slip level", lvl_at(s_slip + 2), 64);
      check("E err count", q_cnt(e_cyc, p_e, p_f - 1), 1);
      check("E err cycle", q_cnt(e_cyc, s_slip + 40, s_slip + 40), 1);
      check("E lock fall", q_cnt(lf_cyc, s_slip + 40, s_slip + 40), 1);
      check("E no partial", q_cnt(v_cyc, s_slip + 3, s_slip + 1062), 0);
      check("E relock level", lvl_at(s_slip + 1063), 64);
      check("E relock rise", q_cnt(lr_cyc, s_slip + 1063, s_slip + 1063), 1);

      // Stuck high: full-scale level and an error on every frame close.
      for (int k = 0; k < 3; k++) begin
         check($sformatf("F level %0d", k), lvl_at(p_f + 258 + 256 * k), 255);
         check($sformatf("F err %0d", k), q_cnt(e_cyc, p_f + 258 + 256 * k, p_f + 258 + 256 * k), 1);
      end
      check("F err count", q_cnt(e_cyc, p_f, x0), 3);
      check("en no valid", q_cnt(v_cyc, en0 + 1, x0 + 1279), 0);

      // Silence after re-enable: lock at 1024 cycles, zero level each frame.
      check("S lock rise", q_cnt(lr_cyc, x0 + 1024, x0 + 1024), 1);
      check("S level", lvl_at(x0 + 1280), 0);
      check("S sample", smp_at(x0 + 1280), -128);
      check("S period", lvl_at(x0 + 1536), 0);
      check("S errors", q_cnt(e_cyc, x0, x0 + 1600), 0);

      // Asynchronous reset mid-frame, observed before any clock edge.
      check("pre-rst locked", int'(locked_out), 1);
      rst_n_in = 1'b0;
      #2;
      check("async level", int'(level_out), 128);
      check("async sample", int'(sample_out), 0);
      check("async locked", int'(locked_out), 0);
      check("async valid", int'(valid_out), 0);
      check("async err", int'(err_out), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pwm_demod.md
# pwm_demod

Recovers 8-bit audio samples from a single-bit PWM stream produced by the audio `pwm` generator: 256-cycle frame, output high while the frame count is below the level. It aligns to the frame, measures the duty cycle of each frame, and emits one level per frame as a valid-strobed sample in both offset-binary and signed form. It sits on the capture/loopback side of the audio path, feeding volume/recorder logic or checking the keyboard output on board.

## Interface

Parameters:
- FRAME_LEN, 256: PWM frame length in clk_in cycles. Must be a power of two, at most 256.
- LOCK_FRAMES, 4: consecutive aligned frames required to declare lock. Also the number of silent frames before silence-lock.

Ports:
- clk_in, input, 1: system clock (100 MHz).
- rst_n_in, input, 1: reset, asynchronous and active-low. One clock; reset is asynchronous and active-low.
- enable_in, input, 1: demodulator enable. Low is a synchronous clear to HUNT.
- pwm_in, input, 1: PWM stream, asynchronous to clk_in.
- level_out, output, 8: last frame duty count, offset binary.
- sample_out, output, 8: signed form of level_out, equal to {~level_out[7], level_out[6:0]}.
- valid_out, output, 1: one-cycle pulse when level_out/sample_out update.
- locked_out, output, 1: high in LOCKED.
- err_out, output, 1: one-cycle pulse on frame error.

## Operation

Input path:
- pwm_in passes through a 2-flop synchronizer to give s, then one more flop to give s_d.
- A rise is s & ~s_d.
- All counting uses s.

Counters:
- fcnt (8-bit) counts modulo FRAME_LEN every cycle.
- hcnt (9-bit) accumulates s over the frame.
- On a frame close, the closing cycle's sample is included, then hcnt restarts at 0.
- When a frame is forced to restart, the current cycle is frame sample 0 and hcnt loads s.

Frame close:
- Occurs on the cycle fcnt == FRAME_LEN-1.
- Frame level = hcnt, saturated to 255.
- hcnt == FRAME_LEN (stuck high) saturates to 255 and pulses err_out.

States:
- **HUNT**:
  - On a rise: fcnt←0 (forced restart), go to ACQUIRE, good count←0.
  - On LOCK_FRAMES×FRAME_LEN consecutive cycles with s=0: go to LOCKED with the current fcnt phase (silence lock).
- **ACQUIRE**:
  - Rise at fcnt==0: normal.
  - Rise at fcnt≠0: err_out pulse, forced restart, good count←0.
  - Each frame close without error increments the good count.
  - When the count reaches LOCK_FRAMES, go to LOCKED and emit that frame.
- **LOCKED**:
  - Every frame close emits level_out/sample_out with valid_out.
  - Rise at fcnt≠0: err_out pulse, forced restart, go to ACQUIRE, locked_out low. The partial frame is not emitted.

Other behaviour:
- Rise and frame close on the same cycle (fcnt==FRAME_LEN-1, early rise): the error takes priority; the frame is discarded.
- enable_in low: state HUNT, fcnt/hcnt/good count ← 0, valid_out/err_out/locked_out low, level_out/sample_out hold.
- rst_n_in low (any time, including mid-frame):
  - level_out = 8'd128, sample_out = 8'sd0, valid_out = 0, locked_out = 0, err_out = 0.
  - State HUNT, synchronizer flops and counters 0.

## Timing

- pwm_in to s: 2 cycles. To rise detection: 3 cycles.
- Frame close to valid_out: 1 cycle. level_out/sample_out are registered and change on the same edge that valid_out rises.
- valid_out period is exactly FRAME_LEN cycles while LOCKED.
- From the first rise after reset to the first valid_out: LOCK_FRAMES×FRAME_LEN cycles (1024 at defaults).
- locked_out rises with the first valid_out and falls on the cycle after the error rise.
- err_out rises 1 cycle after the offending rise or stuck-high close.

## Test plan

- **Constant level 100:** drive a 256-cycle PWM model at level 100 → first valid 1024 cycles after the first rise; level_out=100, sample_out=−28; valid every 256 cycles; locked_out=1; err_out never pulses.
- **Extremes:**
  - Level 255 → level_out=255, sample_out=127.
  - Level 1 → level_out=1, sample_out=−127.
  - Level change 100→200 mid-stream → exactly one frame at 100 then 200, no error.
- **Silence:** pwm_in held 0 → LOCKED after 1024 cycles; level_out=0, sample_out=−128 every 256 cycles.
- **Phase slip:** at level 64, insert 37 extra low cycles → one err_out pulse; locked_out low; no valid for the partial frame; relock after 4 frames.
- **Stuck high:** pwm_in held 1 after lock → level_out=255 and err_out pulse every frame.
- **Reset and enable:**
  - Assert rst_n_in mid-frame in LOCKED → all outputs at reset values immediately, without a clock edge.
  - Drop enable_in → HUNT; level_out holds.
